gauss_row_feeder: RTL and testbench
===================================

# gauss_row_feeder

Upstream injector for the processing-element array. Accepts a command (op code, gauss sub-op, row count), then streams full rows of GF elements. Each row is presented to the array's top edge with a one-cycle skew per column, as the systolic schedule requires. Drives the data, op, gauss_op and start tokens of every column, inserts bubbles when the source stalls, and reports completion once the last row has fully entered the array.

## Interface
- GF_BIT, 4: field element width (4 or 8)
- OP_CODE_LEN, 4: op code width
- NUM_PROC_COL, 3: array columns; ≥2
- CNT_W, 8: row-count width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_op  in  OP_CODE_LEN  op code applied to all rows of the command
- cmd_gauss_op  in  2  gauss sub-op applied to all rows
- cmd_rows  in  CNT_W  number of rows to stream
- row_valid / row_ready  in/out  1  row handshake
- row_data  in  NUM_PROC_COL*GF_BIT  row; column c at bits [c*GF_BIT +: GF_BIT]
- out_ready  in  1  array may advance (used only with FEEDER_STALL_EN)
- col_data  out  NUM_PROC_COL*GF_BIT  per-column data token
- col_op  out  NUM_PROC_COL*OP_CODE_LEN  per-column op token
- col_gauss_op  out  NUM_PROC_COL*2  per-column gauss sub-op token
- col_start  out  NUM_PROC_COL  per-column start token
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE:
  - cmd_ready=1 and row_ready=0.
  - On a cmd handshake, latch op, gauss_op and rows.
  - cmd_rows=0: go straight to DRAIN with zero drain count; done fires the next cycle and nothing is emitted.
  - Otherwise go to FEED.
- FEED:
  - cmd_ready=0 and row_ready=1 (gated by advance, see Configuration).
  - Each row handshake injects {row element c, latched op, latched gauss_op, first-row flag} into the column-c skew line and decrements the remaining count.
  - Cycles with row_valid=0 inject a bubble: data 0, op 0 (NOP), gauss_op 2'b00 (pass), start 0.
  - After the last row: go to DRAIN with drain count NUM_PROC_COL.
- DRAIN:
  - Inject bubbles while the count decrements.
  - At zero: pulse done, return to IDLE.
- Skew: column c output is the column-0 injection delayed by c+1 registers.
- col_start[c] is high only for the token of the first row of a command.
- A new command is accepted in the cycle done is high (cmd_ready=1 there).
- Row count is modulo-free: the counter must not wrap, since it is loaded ≤ 2^CNT_W−1 and only decrements to 0.

## Timing
- Reset (asynchronous assert, synchronous-deassert handled upstream):
  - FSM goes to IDLE, counters clear.
  - Every skew register clears, so all col_* outputs and done read 0.
- Reset mid-command discards in-flight tokens with no done.
- Latency: a row accepted at cycle t appears on column c in cycle t+1+c.
- Last row accepted at t: column NUM_PROC_COL−1 holds it in cycle t+NUM_PROC_COL, and done=1 in cycle t+NUM_PROC_COL+1.
- Throughput: one row per cycle. Back-to-back rows produce no bubbles.
- row_ready and cmd_ready are registered-state functions with no combinational dependence on row_valid or cmd_valid. The dependence on out_ready is an exception and applies only with the macro defined.
- Simultaneous cmd_valid and row_valid in IDLE: only the command is taken. The first row is accepted no earlier than the next cycle.

## Configuration
- FEEDER_STALL_EN
  - Defined: advance = out_ready. When out_ready=0, all skew registers, counters and FSM hold; row_ready=0, cmd_ready=0 and done holds.
  - Undefined: advance is constant 1, out_ready is ignored, and the array never stalls.

## Structure
- Shared package `gf_array_pkg`:
  - Op codes: OP_NOP=0, OP_GAUSS=1, OP_LOAD_KEY=3, OP_EVAL=4, OP_SHIFT_B=5, OP_MUL_RAND=6, OP_LOAD_RAND=7, OP_READ=8, OP_ACC=9.
  - Gauss sub-ops: G_PASS=2'b00, G_PIVOT=2'b01, G_ADD=2'b10, G_HOLD=2'b11.
  - FSM state encoding.
- Sub-module `token_skew_line`: parameterised depth and width, enable input, async-clear register chain. Instantiated once per column with depth c+1 and width GF_BIT+OP_CODE_LEN+3.

## Test plan
All scenarios use NUM_PROC_COL=3 and GF_BIT=4.
- Reset then idle: all col_* outputs = 0, done = 0, cmd_ready = 1.
- Command op=1, gauss=2'b01, rows=2; rows 0x321 and 0x654 back-to-back from t=0:
  - col0 data=1, start=1 at t=1; col2 data=3 at t=3.
  - col0 data=4, start=0 at t=2; col2 data=6 at t=4.
  - done at t=5.
- Same command with row_valid low for one cycle between rows: a bubble (op 0, gauss 00, data 0) propagates through every column, and done is delayed by one cycle.
- cmd_rows=0: done one cycle after the command handshake; no nonzero token is ever emitted.
- With FEEDER_STALL_EN, out_ready=0 for 2 cycles mid-stream: all outputs frozen and row_ready=0. Done is delayed by exactly 2 cycles and the token order is unchanged.
- rst_n asserted while rows are in flight: outputs are 0 within the same cycle, no done is produced, and the next command behaves as from fresh reset.

Source files
------------

// File: rtl/gf_array_pkg.sv
// Shared definitions for the GF processing-element array: op codes, gauss sub-ops, feeder FSM states.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package gf_array_pkg;

  // Array op codes carried on the per-column op token
  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_GAUSS     = 4'd1;
  localparam logic [3:0] OP_LOAD_KEY  = 4'd3;
  localparam logic [3:0] OP_EVAL      = 4'd4;
  localparam logic [3:0] OP_SHIFT_B   = 4'd5;
  localparam logic [3:0] OP_MUL_RAND  = 4'd6;
  localparam logic [3:0] OP_LOAD_RAND = 4'd7;
  localparam logic [3:0] OP_READ      = 4'd8;
  localparam logic [3:0] OP_ACC       = 4'd9;

  // Gauss sub-operations
  typedef enum logic [1:0] {
    G_PASS  = 2'b00,
    G_PIVOT = 2'b01,
    G_ADD   = 2'b10,
    G_HOLD  = 2'b11
  } gauss_op_e;

  // Row feeder FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_e;

  // Width of one column token: {data, op, gauss_op, start}
  function automatic int tok_width(input int gf_bit, input int op_len);
    return gf_bit + op_len + 3;
  endfunction

endpackage

// File: rtl/gauss_row_feeder_if.sv
// Command, row and per-column token bundle between row source, feeder and PE array.
// Latency: none (wiring only).
// Backpressure: cmd/row use valid-ready; out_ready stalls the array when the feeder is built with stalls.
interface gauss_row_feeder_if #(
  parameter int GF_BIT       = 4,
  parameter int OP_CODE_LEN  = 4,
  parameter int NUM_PROC_COL = 3,
  parameter int CNT_W        = 8
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [OP_CODE_LEN-1:0]            cmd_op;
  logic [1:0]                        cmd_gauss_op;
  logic [CNT_W-1:0]                  cmd_rows;
  logic                              row_valid;
  logic                              row_ready;
  logic [NUM_PROC_COL*GF_BIT-1:0]    row_data;
  logic                              out_ready;
  logic [NUM_PROC_COL*GF_BIT-1:0]    col_data;
  logic [NUM_PROC_COL*OP_CODE_LEN-1:0] col_op;
  logic [NUM_PROC_COL*2-1:0]         col_gauss_op;
  logic [NUM_PROC_COL-1:0]           col_start;
  logic                              done;

  // Row source / array side
  modport master (
    output cmd_valid, cmd_op, cmd_gauss_op, cmd_rows, row_valid, row_data, out_ready,
    input  cmd_ready, row_ready, col_data, col_op, col_gauss_op, col_start, done
  );

  // Feeder side
  modport slave (
    input  cmd_valid, cmd_op, cmd_gauss_op, cmd_rows, row_valid, row_data, out_ready,
    output cmd_ready, row_ready, col_data, col_op, col_gauss_op, col_start, done
  );
endinterface

// File: rtl/token_skew_line.sv
// Enable-gated register chain delaying one column token by DEPTH cycles.
// Latency: DEPTH cycles of enabled clocks.
// Backpressure: i_en low freezes every stage.
module token_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the token one stage per enabled cycle; reset empties the whole line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/gauss_row_feeder.sv
// Streams command rows into the PE array top edge with one-cycle skew per column; optional stall via FEEDER_STALL_EN.
// Latency: row accepted at t reaches column c at t+1+c; done at t+NUM_PROC_COL+1 after the last row.
// Backpressure: cmd_ready/row_ready from registered state; with FEEDER_STALL_EN, out_ready=0 freezes everything.
module gauss_row_feeder
  import gf_array_pkg::*;
#(
  parameter int GF_BIT       = 4,
  parameter int OP_CODE_LEN  = 4,
  parameter int NUM_PROC_COL = 3,
  parameter int CNT_W        = 8
) (
  input logic clk,
  input logic rst_n,
  gauss_row_feeder_if.slave bus
);

  localparam int TOK_W = tok_width(GF_BIT, OP_CODE_LEN);

  feed_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [OP_CODE_LEN-1:0] r_op;
  logic [1:0]             r_gop;
  logic                   r_first;
  logic                   r_cmd_rdy;
  logic                   r_row_rdy;
  logic                   r_done;

  logic w_adv;
  logic w_cmd_hs;
  logic w_row_hs;

`ifdef FEEDER_STALL_EN
  assign w_adv = bus.out_ready;
`else
  logic w_unused_out_ready;
  assign w_unused_out_ready = bus.out_ready;
  assign w_adv = 1'b1;
`endif

  assign bus.cmd_ready = r_cmd_rdy & w_adv;
  assign bus.row_ready = r_row_rdy & w_adv;
  assign bus.done      = r_done;
  assign w_cmd_hs      = bus.cmd_valid & bus.cmd_ready;
  assign w_row_hs      = bus.row_valid & bus.row_ready;

  // Command/row sequencing; ready and done flags are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_gop     <= '0;
      r_first   <= 1'b0;
      r_cmd_rdy <= 1'b1;
      r_row_rdy <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_adv) begin
      if (w_cmd_hs) begin
        // Accepted from IDLE or from the done cycle of the previous command
        r_op    <= bus.cmd_op;
        r_gop   <= bus.cmd_gauss_op;
        r_cnt   <= bus.cmd_rows;
        r_first <= 1'b1;
        if (bus.cmd_rows == '0) begin
          r_state   <= ST_DRAIN;
          r_cmd_rdy <= 1'b1;
          r_row_rdy <= 1'b0;
          r_done    <= 1'b1;
        end else begin
          r_state   <= ST_FEED;
          r_cmd_rdy <= 1'b0;
          r_row_rdy <= 1'b1;
          r_done    <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_done <= 1'b0;
          end
          ST_FEED: begin
            if (w_row_hs) begin
              r_first <= 1'b0;
              if (r_cnt == CNT_W'(1)) begin
                r_state   <= ST_DRAIN;
                r_cnt     <= CNT_W'(NUM_PROC_COL);
                r_row_rdy <= 1'b0;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (r_cnt == '0) begin
              r_state   <= ST_IDLE;
              r_cmd_rdy <= 1'b1;
              r_done    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
              // Count reaching zero is the done cycle, which also takes a new command
              if (r_cnt == CNT_W'(1)) begin
                r_done    <= 1'b1;
                r_cmd_rdy <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_cmd_rdy <= 1'b1;
            r_row_rdy <= 1'b0;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  // One skew line per column; bubbles (all-zero tokens) whenever no row is taken
  for (genvar c = 0; c < NUM_PROC_COL; c++) begin : g_col
    logic [TOK_W-1:0] w_inj;
    logic [TOK_W-1:0] w_tok;

    assign w_inj = w_row_hs ? {bus.row_data[c*GF_BIT +: GF_BIT], r_op, r_gop, r_first} : '0;

    token_skew_line #(
      .DEPTH (c + 1),
      .WIDTH (TOK_W)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_adv),
      .i_dat (w_inj),
      .o_dat (w_tok)
    );

    assign bus.col_data[c*GF_BIT +: GF_BIT]               = w_tok[TOK_W-1 -: GF_BIT];
    assign bus.col_op[c*OP_CODE_LEN +: OP_CODE_LEN]       = w_tok[OP_CODE_LEN+2:3];
    assign bus.col_gauss_op[c*2 +: 2]                     = w_tok[2:1];
    assign bus.col_start[c]                               = w_tok[0];
  end

endmodule

// File: tb/tb_gauss_row_feeder.sv
// Scoreboard bench for gauss_row_feeder: directed scenarios then randomized traffic and resets.
// Latency: expectations derived from a tick-indexed history of accepted rows.
// Backpressure: out_ready randomized; it only takes effect when FEEDER_STALL_EN is defined.
module tb_gauss_row_feeder;
  import gf_array_pkg::*;

  localparam int GF_BIT       = 4;
  localparam int OP_CODE_LEN  = 4;
  localparam int NUM_PROC_COL = 3;
  localparam int CNT_W        = 8;
  localparam int RW           = NUM_PROC_COL*GF_BIT;
  localparam int NEVER        = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gauss_row_feeder_if #(.GF_BIT(GF_BIT), .OP_CODE_LEN(OP_CODE_LEN),
                        .NUM_PROC_COL(NUM_PROC_COL), .CNT_W(CNT_W)) bus ();

  gauss_row_feeder #(.GF_BIT(GF_BIT), .OP_CODE_LEN(OP_CODE_LEN),
                     .NUM_PROC_COL(NUM_PROC_COL), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [RW-1:0]          row;
    logic [OP_CODE_LEN-1:0] op;
    logic [1:0]             gop;
    logic                   start;
  } tok_t;

  typedef struct {
    int                                cyc;
    logic [RW-1:0]                     data;
    logic [NUM_PROC_COL*OP_CODE_LEN-1:0] op;
    logic [NUM_PROC_COL*2-1:0]         gop;
    logic [NUM_PROC_COL-1:0]           start;
    logic                              done;
    logic                              cmd_rdy;
    logic                              row_rdy;
  } exp_t;

  exp_t sb_q[$];
  tok_t inj[int];   // row injected at each advancing tick

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lt     = 0;   // count of cycles in which the array advanced

  // Reference model of the command/row protocol, in advancing-tick time
  bit                     m_feed;
  int                     m_left;
  int                     m_done_lt;
  int                     m_free_lt;
  logic [OP_CODE_LEN-1:0] m_op;
  logic [1:0]             m_gop;
  bit                     m_first;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Drive one cycle, predict this cycle's outputs, then advance the model
  task automatic step(input bit cv, input logic [3:0] op, input logic [1:0] gop,
                      input logic [7:0] rows, input bit rv, input logic [RW-1:0] rd,
                      input bit orv);
    exp_t e;
    tok_t t;
    bit   adv;
    bit   idle;
`ifdef FEEDER_STALL_EN
    adv = orv;
`else
    adv = 1'b1;
`endif
    idle      = (lt >= m_free_lt);
    e.cyc     = cyc;
    e.done    = (lt == m_done_lt);
    e.cmd_rdy = idle && adv;
    e.row_rdy = m_feed && adv;
    e.data    = '0;
    e.op      = '0;
    e.gop     = '0;
    e.start   = '0;
    for (int c = 0; c < NUM_PROC_COL; c++) begin
      if (inj.exists(lt-1-c)) begin
        e.data[c*GF_BIT +: GF_BIT]          = inj[lt-1-c].row[c*GF_BIT +: GF_BIT];
        e.op[c*OP_CODE_LEN +: OP_CODE_LEN]  = inj[lt-1-c].op;
        e.gop[c*2 +: 2]                     = inj[lt-1-c].gop;
        e.start[c]                          = inj[lt-1-c].start;
      end
    end
    sb_q.push_back(e);

    bus.cmd_valid    = cv;
    bus.cmd_op       = op;
    bus.cmd_gauss_op = gop;
    bus.cmd_rows     = rows;
    bus.row_valid    = rv;
    bus.row_data     = rd;
    bus.out_ready    = orv;

    if (adv) begin
      if (cv && idle) begin
        m_op      = op;
        m_gop     = gop;
        m_first   = 1'b1;
        m_done_lt = -1;
        if (rows == 0) begin
          m_done_lt = lt + 1;
          m_free_lt = lt + 1;
        end else begin
          m_feed    = 1'b1;
          m_left    = rows;
          m_free_lt = NEVER;
        end
      end else if (rv && m_feed) begin
        t.row   = rd;
        t.op    = m_op;
        t.gop   = m_gop;
        t.start = m_first;
        inj[lt] = t;
        m_first = 1'b0;
        m_left--;
        if (m_left == 0) begin
          m_feed    = 1'b0;
          m_done_lt = lt + NUM_PROC_COL + 1;
          m_free_lt = m_done_lt;
        end
      end
      lt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'b00, 8'd0, 1'b0, '0, 1'b1);
  endtask

  task automatic model_clear();
    inj.delete();
    m_feed    = 1'b0;
    m_left    = 0;
    m_done_lt = -1;
    m_free_lt = lt;
    m_first   = 1'b0;
  endtask

  // Assert reset mid-cycle, outputs must clear at once; release a cycle later
  task automatic mid_reset();
    bus.cmd_valid = 1'b0;
    bus.row_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_col_data", 32'(bus.col_data), 32'd0);
    chk("rst_col_op", 32'(bus.col_op), 32'd0);
    chk("rst_col_gop", 32'(bus.col_gauss_op), 32'd0);
    chk("rst_col_start", 32'(bus.col_start), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_row_ready", 32'(bus.row_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  // Monitor: compare every cycle that has a scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) void'(sb_q.pop_front());
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        chk("col_data", 32'(bus.col_data), 32'(e.data));
        chk("col_op", 32'(bus.col_op), 32'(e.op));
        chk("col_gauss_op", 32'(bus.col_gauss_op), 32'(e.gop));
        chk("col_start", 32'(bus.col_start), 32'(e.start));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(e.cmd_rdy));
        chk("row_ready", 32'(bus.row_ready), 32'(e.row_rdy));
      end
    end
  end

  initial begin
    bit       cv;
    bit       idle;
    bit [7:0] rows;
    rst_n            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = '0;
    bus.cmd_gauss_op = '0;
    bus.cmd_rows     = '0;
    bus.row_valid    = 1'b0;
    bus.row_data     = '0;
    bus.out_ready    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("init_col_data", 32'(bus.col_data), 32'd0);
    chk("init_col_op", 32'(bus.col_op), 32'd0);
    chk("init_col_start", 32'(bus.col_start), 32'd0);
    chk("init_done", 32'(bus.done), 32'd0);
    chk("init_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;

    // Two back-to-back rows; a row offered with the command must be ignored
    step(1'b1, OP_GAUSS, G_PIVOT, 8'd2, 1'b1, 12'h321, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h321, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b1);
    idle_n(6);

    // One source bubble between the rows
    step(1'b1, OP_GAUSS, G_PIVOT, 8'd2, 1'b0, '0, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h321, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 12'hfff, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b1);
    idle_n(6);

    // Zero-row command, then a new command taken in the done cycle
    step(1'b1, OP_EVAL, G_ADD, 8'd0, 1'b1, 12'habc, 1'b1);
    step(1'b1, OP_ACC, G_HOLD, 8'd1, 1'b1, 12'h987, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h987, 1'b1);
    idle_n(6);

`ifdef FEEDER_STALL_EN
    // Two stalled cycles between the rows
    step(1'b1, OP_GAUSS, G_PIVOT, 8'd2, 1'b0, '0, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h321, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b0);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b0);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b1);
    idle_n(7);
`endif

    // Reset with rows in flight, then the first scenario from fresh state
    step(1'b1, OP_READ, G_ADD, 8'd4, 1'b0, '0, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h5a5, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'hc3c, 1'b1);
    mid_reset();
    step(1'b1, OP_GAUSS, G_PIVOT, 8'd2, 1'b0, '0, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h321, 1'b1);
    step(1'b0, 4'd0, 2'b00, 8'd0, 1'b1, 12'h654, 1'b1);
    idle_n(6);

    // Randomized traffic with garbage handshakes outside ready windows
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        mid_reset();
      end else begin
        idle = (lt >= m_free_lt);
        cv   = idle ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
        rows = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        step(cv, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rows,
             ($urandom_range(0, 3) != 0), RW'($urandom), ($urandom_range(0, 4) != 0));
      end
    end
    idle_n(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
